// File: rtl/vend_ctrl_multi_if.sv
// Front-end / back-end bus of the multi-product vending controller.
// master: coin acceptor, keypad and dispensers (the environment).
// slave : the controller itself.
interface vend_ctrl_multi_if #(
    parameter int NUM_PRODUCTS = 4,
    parameter int SEL_W        = 2,
    parameter int PRICE_W      = 8,
    parameter int CREDIT_W     = 10
) ();
    logic                            tick_en;
    logic                            coin_valid;
    logic [PRICE_W-1:0]              coin_value;
    logic                            cancel;
    logic                            sel_valid;
    logic [SEL_W-1:0]                sel_id;
    logic [NUM_PRODUCTS*PRICE_W-1:0] price_flat;
    logic [NUM_PRODUCTS-1:0]         stock_avail;
    logic                            prod_done;
    logic                            chg_done;
    logic                            coin_accept;
    logic                            coin_reject;
    logic                            sel_nack;
    logic [CREDIT_W-1:0]             credit;
    logic                            prod_req;
    logic [SEL_W-1:0]                prod_id;
    logic                            chg_req;
    logic [CREDIT_W-1:0]             chg_amount;
    logic                            fault;
    logic [2:0]                      state_out;

    modport master (
        output tick_en, coin_valid, coin_value, cancel, sel_valid, sel_id,
               price_flat, stock_avail, prod_done, chg_done,
        input  coin_accept, coin_reject, sel_nack, credit, prod_req, prod_id,
               chg_req, chg_amount, fault, state_out
    );

    modport slave (
        input  tick_en, coin_valid, coin_value, cancel, sel_valid, sel_id,
               price_flat, stock_avail, prod_done, chg_done,
        output coin_accept, coin_reject, sel_nack, credit, prod_req, prod_id,
               chg_req, chg_amount, fault, state_out
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulator, per-product
// price/stock check, tick-based timeouts, req/done handshakes to the
// product and change dispensers.
// Optional macro MULTI_VEND_EN: after a vend with credit left, return to
// WAIT_COIN for further purchases instead of paying change immediately.
module vend_ctrl_multi #(
    parameter int NUM_PRODUCTS = 4,
    parameter int SEL_W        = 2,
    parameter int PRICE_W      = 8,
    parameter int CREDIT_W     = 10,
    parameter int MAX_CREDIT   = 500,
    parameter int SEL_TIMEOUT  = 30,
    parameter int DISP_TIMEOUT = 5,
    parameter int CHG_TIMEOUT  = 10
) (
    input logic              clk,
    input logic              rst_n,
    vend_ctrl_multi_if.slave bus
);
    localparam int TMAX = (SEL_TIMEOUT > DISP_TIMEOUT)
                        ? ((SEL_TIMEOUT > CHG_TIMEOUT) ? SEL_TIMEOUT : CHG_TIMEOUT)
                        : ((DISP_TIMEOUT > CHG_TIMEOUT) ? DISP_TIMEOUT : CHG_TIMEOUT);
    localparam int TMR_W = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE          = 3'b000,
        WAIT_COIN     = 3'b001,
        DISPENSE_PROD = 3'b011,
        DISPENSE_CHG  = 3'b100,
        FAULT         = 3'b111
    } state_t;

    state_t              state_q, state_nx;
    logic [CREDIT_W-1:0] credit_q, credit_nx;
    logic [CREDIT_W-1:0] chg_q, chg_nx;
    logic [TMR_W-1:0]    timer_q, timer_nx;
    logic [PRICE_W-1:0]  paid_q, paid_nx;
    logic [SEL_W-1:0]    pid_q, pid_nx;
    logic                fault_q, fault_nx;
    logic                acc_q, acc_nx, rej_q, rej_nx, nack_q, nack_nx;

    logic [PRICE_W-1:0]  sel_price;
    logic                sel_stock, sel_in;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fit;
    logic [CREDIT_W-1:0] sel_price_ext, paid_ext;

    // Price/stock lookup; an index beyond the table is simply "not in range".
    always_comb begin
        sel_price = '0;
        sel_stock = 1'b0;
        sel_in    = 1'b0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (bus.sel_id == SEL_W'(i)) begin
                sel_price = bus.price_flat[i*PRICE_W +: PRICE_W];
                sel_stock = bus.stock_avail[i];
                sel_in    = 1'b1;
            end
        end
    end

    // Overflow check runs one bit wider than the credit register.
    assign coin_sum      = {1'b0, credit_q} + {{(CREDIT_W+1-PRICE_W){1'b0}}, bus.coin_value};
    assign coin_fit      = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign sel_price_ext = {{(CREDIT_W-PRICE_W){1'b0}}, sel_price};
    assign paid_ext      = {{(CREDIT_W-PRICE_W){1'b0}}, paid_q};

    // Next-state, datapath and pulse decode.
    always_comb begin
        state_nx  = state_q;
        credit_nx = credit_q;
        chg_nx    = chg_q;
        timer_nx  = timer_q;
        paid_nx   = paid_q;
        pid_nx    = pid_q;
        fault_nx  = fault_q;
        acc_nx    = 1'b0;
        nack_nx   = 1'b0;
        rej_nx    = bus.coin_valid;   // only an accepted coin in WAIT_COIN clears this
        case (state_q)
            IDLE: state_nx = WAIT_COIN;
            WAIT_COIN: begin
                if (bus.cancel) begin
                    if (credit_q != '0) begin
                        state_nx = DISPENSE_CHG;
                        chg_nx   = credit_q;
                    end
                end else if (bus.sel_valid) begin
                    if (sel_in && sel_stock && credit_q >= sel_price_ext) begin
                        pid_nx    = bus.sel_id;
                        paid_nx   = sel_price;
                        credit_nx = credit_q - sel_price_ext;
                        state_nx  = DISPENSE_PROD;
                    end else begin
                        nack_nx = 1'b1;
                    end
                end else if (bus.coin_valid && coin_fit) begin
                    rej_nx    = 1'b0;
                    acc_nx    = 1'b1;
                    credit_nx = coin_sum[CREDIT_W-1:0];
                    timer_nx  = '0;
                end else if (bus.tick_en && credit_q != '0) begin
                    if (timer_q == TMR_W'(SEL_TIMEOUT-1)) begin
                        state_nx = DISPENSE_CHG;
                        chg_nx   = credit_q;
                    end else begin
                        timer_nx = timer_q + 1'b1;
                    end
                end
            end
            DISPENSE_PROD: begin
                if (bus.prod_done) begin
                    if (credit_q != '0) begin
`ifdef MULTI_VEND_EN
                        state_nx = WAIT_COIN;
`else
                        state_nx = DISPENSE_CHG;
                        chg_nx   = credit_q;
`endif
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (bus.tick_en) begin
                    if (timer_q == TMR_W'(DISP_TIMEOUT-1)) begin
                        // Product never came out: give the money back.
                        fault_nx  = 1'b1;
                        credit_nx = credit_q + paid_ext;
                        chg_nx    = credit_q + paid_ext;
                        state_nx  = DISPENSE_CHG;
                    end else begin
                        timer_nx = timer_q + 1'b1;
                    end
                end
            end
            DISPENSE_CHG: begin
                if (bus.chg_done) begin
                    credit_nx = '0;
                    state_nx  = IDLE;
                end else if (bus.tick_en) begin
                    if (timer_q == TMR_W'(CHG_TIMEOUT-1)) begin
                        fault_nx = 1'b1;
                        state_nx = FAULT;
                    end else begin
                        timer_nx = timer_q + 1'b1;
                    end
                end
            end
            FAULT:   state_nx = FAULT;
            default: state_nx = IDLE;
        endcase
        if (state_nx != state_q) timer_nx = '0;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            chg_q    <= '0;
            timer_q  <= '0;
            paid_q   <= '0;
            pid_q    <= '0;
            fault_q  <= 1'b0;
            acc_q    <= 1'b0;
            rej_q    <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            credit_q <= credit_nx;
            chg_q    <= chg_nx;
            timer_q  <= timer_nx;
            paid_q   <= paid_nx;
            pid_q    <= pid_nx;
            fault_q  <= fault_nx;
            acc_q    <= acc_nx;
            rej_q    <= rej_nx;
            nack_q   <= nack_nx;
        end
    end

    assign bus.coin_accept = acc_q;
    assign bus.coin_reject = rej_q;
    assign bus.sel_nack    = nack_q;
    assign bus.credit      = credit_q;
    assign bus.prod_req    = (state_q == DISPENSE_PROD);
    assign bus.prod_id     = pid_q;
    assign bus.chg_req     = (state_q == DISPENSE_CHG);
    assign bus.chg_amount  = chg_q;
    assign bus.fault       = fault_q;
    assign bus.state_out   = state_q;
endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised vending-machine controller: next generation of the single-product FSM controller.
- Integrates a credit accumulator, per-product price/stock checking and tick-based timeouts.
- Drives req/done handshakes to the product dispenser and the change dispenser.
- Sits between the coin acceptor/keypad front end and the dispenser/display back ends.

Parameters:
- NUM_PRODUCTS, 4, number of selectable products (2..16)
- SEL_W, 2, width of product index; must satisfy 2**SEL_W >= NUM_PRODUCTS
- PRICE_W, 8, width of a coin value and of one price entry
- CREDIT_W, 10, width of the credit register; must be > PRICE_W
- MAX_CREDIT, 500, highest credit accepted; a coin that would exceed it is rejected
- SEL_TIMEOUT, 30, tick_en pulses of inactivity in WAIT_COIN with credit>0 before auto-refund
- DISP_TIMEOUT, 5, tick_en pulses allowed for prod_done
- CHG_TIMEOUT, 10, tick_en pulses allowed for chg_done

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- tick_en  in  1  one-cycle timebase pulse used by all timeouts
- coin_valid  in  1  coin present this cycle
- coin_value  in  PRICE_W  value of the coin
- cancel  in  1  user cancel request (level, sampled each cycle)
- sel_valid  in  1  product selection strobe
- sel_id  in  SEL_W  selected product index
- price_flat  in  NUM_PRODUCTS*PRICE_W  price table; entry i at bits [i*PRICE_W +: PRICE_W]
- stock_avail  in  NUM_PRODUCTS  1 = product i in stock
- prod_done  in  1  dispenser completion pulse
- chg_done  in  1  change dispenser completion pulse
- coin_accept  out  1  one-cycle pulse: coin added to credit
- coin_reject  out  1  one-cycle pulse: coin returned
- sel_nack  out  1  one-cycle pulse: selection refused (bad index, no stock, insufficient credit)
- credit  out  CREDIT_W  current credit
- prod_req  out  1  held high in DISPENSE_PROD
- prod_id  out  SEL_W  latched product index, stable while prod_req=1
- chg_req  out  1  held high in DISPENSE_CHG
- chg_amount  out  CREDIT_W  refund amount, stable while chg_req=1
- fault  out  1  sticky; set on any dispenser timeout; cleared only by reset
- state_out  out  3  current state encoding

Behaviour:
- State encodings: IDLE=000, WAIT_COIN=001, DISPENSE_PROD=011, DISPENSE_CHG=100, FAULT=111.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; credit=0; timer=0; fault=0.
  - All pulse and req outputs = 0; prod_id=0; chg_amount=0.
  - Applies from any state, including mid-handshake; no refund is issued.
- IDLE: unconditionally -> WAIT_COIN next cycle. coin_valid in IDLE -> coin_reject.
- WAIT_COIN, same-cycle priority cancel > sel_valid > coin_valid:
  - cancel: credit>0 -> DISPENSE_CHG; credit=0 -> stays in WAIT_COIN.
  - sel_valid: accepted if sel_id<NUM_PRODUCTS, stock_avail[sel_id]=1 and credit>=price.
    - Accepted: latch prod_id, credit<=credit-price, -> DISPENSE_PROD.
    - Refused: sel_nack pulse, credit unchanged.
  - coin_valid accepted only if neither cancel nor sel_valid is active and credit+coin_value<=MAX_CREDIT.
    - Accepted: credit updated next cycle, coin_accept pulse, timer cleared.
    - Otherwise: coin_reject pulse, credit unchanged.
  - Timer counts tick_en only while credit>0; at SEL_TIMEOUT -> DISPENSE_CHG.
- DISPENSE_PROD: prod_req=1.
  - prod_done: credit>0 -> DISPENSE_CHG; credit=0 -> IDLE.
  - Timeout (DISP_TIMEOUT ticks): fault=1, price restored into credit, -> DISPENSE_CHG.
- DISPENSE_CHG: chg_amount=credit latched on entry; chg_req=1.
  - chg_done: credit=0 -> IDLE.
  - Timeout (CHG_TIMEOUT ticks): fault=1 -> FAULT.
- FAULT: all req=0, every coin rejected, exit only by reset.
- Any coin_valid outside WAIT_COIN -> coin_reject.
- Timer clears on every state entry.
- prod_done/chg_done arriving outside their state are ignored.
- Timeout and done in the same cycle: done wins.
- Credit arithmetic is unsigned, CREDIT_W bits; the overflow check uses CREDIT_W+1 bits.

Optional Feature:
- Macro MULTI_VEND_EN.
- Defined: after prod_done with credit>0, -> WAIT_COIN (timer cleared) so further purchases can be made; change is issued only on cancel or SEL_TIMEOUT.
- Undefined: remaining credit always goes to DISPENSE_CHG after a vend, as described above.

Test Plan:
- Reset, then coins 100+100+50, select id 2 (price 200, in stock), prod_done after 3 cycles -> credit 250->50; prod_req held with prod_id=2; chg_req with chg_amount=50; chg_done -> IDLE, credit 0.
- Credit 450, coin 100 -> coin_reject pulse, credit stays 450; coin 50 -> coin_accept, credit 500.
- Credit 150, select id 1 (price 200) -> sel_nack; select id 3 with stock_avail[3]=0 -> sel_nack; credit unchanged at 150.
- Credit 120, no activity for 30 tick_en pulses -> DISPENSE_CHG with chg_amount=120.
- Vend accepted, prod_done never asserted for 5 ticks -> fault=1, refund equals full price plus remainder; then chg_done withheld 10 ticks -> state_out=111, coins rejected.
- rst_n low during DISPENSE_PROD -> next cycle state_out=000, prod_req=0, credit=0, fault=0; cancel and sel_valid in the same cycle -> cancel path taken.
